// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types: frame FSM states and the scan-code prefix bytes.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Bytes still to swallow after the Pause lead-in byte.
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    // PS/2 frames carry odd parity over the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter for one PS/2 line.
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic i_line,
    output logic o_filt
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_filt;

    // r_cnt counts consecutive samples that disagree with the filtered level.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_sync <= 2'b11;
            r_cnt  <= '0;
            r_filt <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_line};
            if (r_sync[1] != r_filt) begin
                if (r_cnt == CW'(FILTER_LEN - 1)) begin
                    r_filt <= r_sync[1];
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frames bytes, folds E0/F0/E1 prefixes into key events.
// Define PS2_PARITY_CHECK_EN to reject frames with bad (even) parity.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_strobe,
    output logic       key_pressed,
    output logic       key_extended,
    output logic [7:0] key_code,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic w_clk_f;
    logic w_data_f;
    logic w_fall;
    logic w_par_ok;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_line  (ps2_clk),
        .o_filt  (w_clk_f)
    );

    // Data gets the same filter so it stays aligned with the filtered clock.
    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_line  (ps2_data),
        .o_filt  (w_data_f)
    );

    ps2_state_e    r_state;
    logic          r_clk_prev;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [TW-1:0] r_tmo;
    logic          r_ext;
    logic          r_brk;
    logic [2:0]    r_skip;

    assign w_fall = r_clk_prev & ~w_clk_f;

`ifdef PS2_PARITY_CHECK_EN
    logic r_par;
    assign w_par_ok = odd_parity_ok(r_shift, r_par);
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_clk_prev   <= 1'b1;
            r_bit        <= '0;
            r_shift      <= '0;
            r_tmo        <= '0;
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_skip       <= '0;
            key_strobe   <= 1'b0;
            key_pressed  <= 1'b0;
            key_extended <= 1'b0;
            key_code     <= 8'h00;
            frame_err    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            r_par        <= 1'b0;
`endif
        end else begin
            key_strobe <= 1'b0;
            frame_err  <= 1'b0;
            r_clk_prev <= w_clk_f;

            if (r_state == ST_IDLE || w_fall)
                r_tmo <= '0;
            else
                r_tmo <= r_tmo + 1'b1;

            if (r_state != ST_IDLE && !w_fall && r_tmo == TW'(TIMEOUT_CYC - 1)) begin
                r_state   <= ST_IDLE;
                frame_err <= 1'b1;
                r_ext     <= 1'b0;
                r_brk     <= 1'b0;
                r_skip    <= '0;
            end else if (w_fall) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_data_f) begin
                            r_state <= ST_DATA;
                            r_bit   <= '0;
                        end
                    end
                    ST_DATA: begin
                        r_shift <= {w_data_f, r_shift[7:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7)
                            r_state <= ST_PARITY;
                    end
                    ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        r_par <= w_data_f;
`endif
                        r_state <= ST_STOP;
                    end
                    ST_STOP: begin
                        r_state <= ST_IDLE;
                        if (!w_data_f || !w_par_ok) begin
                            frame_err <= 1'b1;
                            r_ext     <= 1'b0;
                            r_brk     <= 1'b0;
                            r_skip    <= '0;
                        end else if (r_skip != '0) begin
                            r_skip <= r_skip - 1'b1;
                        end else if (r_shift == PS2_PAUSE) begin
                            r_skip <= PS2_PAUSE_SKIP;
                        end else if (r_shift == PS2_EXT) begin
                            r_ext <= 1'b1;
                        end else if (r_shift == PS2_BRK) begin
                            r_brk <= 1'b1;
                        end else begin
                            key_strobe   <= 1'b1;
                            key_code     <= r_shift;
                            key_pressed  <= ~r_brk;
                            key_extended <= r_ext;
                            r_ext        <= 1'b0;
                            r_brk        <= 1'b0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: PS/2 frames in, expected key events queued.
module tb_ps2_key_decoder;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 400;

    logic       clk_sys;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic       key_strobe;
    logic       key_pressed;
    logic       key_extended;
    logic [7:0] key_code;
    logic       frame_err;

    ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_strobe   (key_strobe),
        .key_pressed  (key_pressed),
        .key_extended (key_extended),
        .key_code     (key_code),
        .frame_err    (frame_err)
    );

    typedef struct {
        logic [7:0] code;
        logic       pressed;
        logic       ext;
    } ev_t;

    ev_t exp_q[$];
    int  n_total = 0;
    int  n_pass  = 0;
    int  n_strobe = 0;
    int  n_err = 0;

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Scoreboard: every strobe must match the oldest queued event.
    always @(negedge clk_sys) begin
        if (key_strobe) begin
            n_strobe++;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_strobe: got code %02h pressed %0b ext %0b, wanted none",
                         key_code, key_pressed, key_extended);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if ({key_code, key_pressed, key_extended} !== {e.code, e.pressed, e.ext})
                    $display("FAIL event: got code %02h pressed %0b ext %0b, wanted code %02h pressed %0b ext %0b",
                             key_code, key_pressed, key_extended, e.code, e.pressed, e.ext);
                else
                    n_pass++;
            end
        end
        if (frame_err) n_err++;
    end

    task automatic sys_wait(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        ps2_data = b;
        if (glitch) begin
            sys_wait(8);
            ps2_clk = 1'b0;
            sys_wait(2);
            ps2_clk = 1'b1;
            sys_wait(10);
        end else begin
            sys_wait(20);
        end
        ps2_clk = 1'b0;
        sys_wait(20);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                              input logic glitch);
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
        send_bit(bad_par ? ^b : ~^b, glitch);
        send_bit(bad_stop ? 1'b0 : 1'b1, glitch);
        ps2_data = 1'b1;
        sys_wait(20);
    endtask

    task automatic push_ev(input logic [7:0] code, input logic pressed, input logic ext);
        ev_t e;
        e.code = code;
        e.pressed = pressed;
        e.ext = ext;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        int s0, e0;
        reset_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        sys_wait(5);
        n_total++;
        if ({key_strobe, key_pressed, key_extended, frame_err, key_code} !== 12'h000)
            $display("FAIL reset_outputs: got strobe %0b pressed %0b ext %0b err %0b code %02h, wanted all 0",
                     key_strobe, key_pressed, key_extended, frame_err, key_code);
        else n_pass++;
        reset_n = 1'b1;
        sys_wait(5);
        s0 = n_strobe;
        e0 = n_err;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        reset_n = 1'b0;
        sys_wait(3);
        reset_n = 1'b1;
        ps2_data = 1'b1;
        sys_wait(TIMEOUT_CYC + 100);
        n_total++;
        if (n_strobe - s0 !== 0 || n_err - e0 !== 0)
            $display("FAIL reset_midframe: got %0d strobes %0d errors, wanted 0 and 0",
                     n_strobe - s0, n_err - e0);
        else n_pass++;
    endtask

    task automatic test_make;
        int s0, e0;
        s0 = n_strobe;
        e0 = n_err;
        push_ev(8'h1C, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (n_strobe - s0 !== 1 || n_err - e0 !== 0)
            $display("FAIL make_count: got %0d strobes %0d errors, wanted 1 and 0", n_strobe - s0, n_err - e0);
        else n_pass++;
    endtask

    task automatic test_break;
        int s0;
        s0 = n_strobe;
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (n_strobe - s0 !== 0 || key_code !== 8'h1C || key_pressed !== 1'b1)
            $display("FAIL break_prefix_hold: got %0d strobes code %02h pressed %0b, wanted 0, 1c, 1",
                     n_strobe - s0, key_code, key_pressed);
        else n_pass++;
        push_ev(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (n_strobe - s0 !== 1)
            $display("FAIL break_count: got %0d strobes, wanted 1", n_strobe - s0);
        else n_pass++;
    endtask

    task automatic test_extended;
        int s0;
        s0 = n_strobe;
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (n_strobe - s0 !== 0 || key_code !== 8'h1C || key_extended !== 1'b0)
            $display("FAIL ext_prefix_hold: got %0d strobes code %02h ext %0b, wanted 0, 1c, 0",
                     n_strobe - s0, key_code, key_extended);
        else n_pass++;
        push_ev(8'h75, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b0, 1'b0);
        push_ev(8'h75, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0, 1'b0);
        push_ev(8'h74, 1'b1, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h74, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (n_strobe - s0 !== 3)
            $display("FAIL ext_count: got %0d strobes, wanted 3", n_strobe - s0);
        else n_pass++;
    endtask

    task automatic test_parity;
        int s0, e0;
        s0 = n_strobe;
        e0 = n_err;
`ifdef PS2_PARITY_CHECK_EN
        send_frame(8'h45, 1'b1, 1'b0, 1'b0);
        n_total++;
        if (n_strobe - s0 !== 0 || n_err - e0 !== 1)
            $display("FAIL parity_bad: got %0d strobes %0d errors, wanted 0 and 1", n_strobe - s0, n_err - e0);
        else n_pass++;
`else
        push_ev(8'h45, 1'b1, 1'b0);
        send_frame(8'h45, 1'b1, 1'b0, 1'b0);
        n_total++;
        if (n_strobe - s0 !== 1 || n_err - e0 !== 0)
            $display("FAIL parity_ignored: got %0d strobes %0d errors, wanted 1 and 0", n_strobe - s0, n_err - e0);
        else n_pass++;
`endif
    endtask

    task automatic test_stop_err;
        int s0, e0;
        s0 = n_strobe;
        e0 = n_err;
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        n_total++;
        if (n_strobe - s0 !== 0 || n_err - e0 !== 1)
            $display("FAIL stop_bad: got %0d strobes %0d errors, wanted 0 and 1", n_strobe - s0, n_err - e0);
        else n_pass++;
        push_ev(8'h1C, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (n_strobe - s0 !== 1)
            $display("FAIL stop_recover: got %0d strobes, wanted 1", n_strobe - s0);
        else n_pass++;
    endtask

    task automatic test_timeout;
        int s0, e0;
        s0 = n_strobe;
        e0 = n_err;
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1 == 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        ps2_data = 1'b1;
        sys_wait(TIMEOUT_CYC + 50);
        n_total++;
        if (n_strobe - s0 !== 0 || n_err - e0 !== 1)
            $display("FAIL timeout: got %0d strobes %0d errors, wanted 0 and 1", n_strobe - s0, n_err - e0);
        else n_pass++;
        push_ev(8'h16, 1'b1, 1'b0);
        send_frame(8'h16, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (n_strobe - s0 !== 1 || n_err - e0 !== 1)
            $display("FAIL timeout_recover: got %0d strobes %0d errors, wanted 1 and 1", n_strobe - s0, n_err - e0);
        else n_pass++;
    endtask

    task automatic test_glitch_pause;
        int s0, e0;
        logic [7:0] pause_seq [8];
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        s0 = n_strobe;
        e0 = n_err;
        ps2_data = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sys_wait(10);
            ps2_clk = 1'b0;
            sys_wait(2);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        sys_wait(TIMEOUT_CYC + 50);
        n_total++;
        if (n_strobe - s0 !== 0 || n_err - e0 !== 0)
            $display("FAIL glitch_idle: got %0d strobes %0d errors, wanted 0 and 0", n_strobe - s0, n_err - e0);
        else n_pass++;
        for (int i = 0; i < 8; i++) send_frame(pause_seq[i], 1'b0, 1'b0, 1'b1);
        n_total++;
        if (n_strobe - s0 !== 0 || n_err - e0 !== 0)
            $display("FAIL pause_swallow: got %0d strobes %0d errors, wanted 0 and 0", n_strobe - s0, n_err - e0);
        else n_pass++;
        push_ev(8'h29, 1'b1, 1'b0);
        send_frame(8'h29, 1'b0, 1'b0, 1'b1);
        n_total++;
        if (n_strobe - s0 !== 1 || n_err - e0 !== 0)
            $display("FAIL pause_then_key: got %0d strobes %0d errors, wanted 1 and 0", n_strobe - s0, n_err - e0);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int s0;
        logic [7:0] code;
        s0 = n_strobe;
        for (int i = 0; i < 4; i++) begin
            code = 8'h1A + 8'(i);
            push_ev(code, 1'b1, 1'b0);
            send_frame(code, 1'b0, 1'b0, 1'b0);
        end
        n_total++;
        if (n_strobe - s0 !== 4)
            $display("FAIL back_to_back: got %0d strobes, wanted 4", n_strobe - s0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_parity();
        test_stop_err();
        test_timeout();
        test_glitch_pause();
        test_back_to_back();
        sys_wait(50);
        n_total++;
        if (exp_q.size() !== 0)
            $display("FAIL pending_events: got %0d events never seen, wanted 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal ps2_clk samples required before the filtered clock changes.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000: clk_sys cycles allowed between falling edges inside a frame.
REQ-003 SHALL have port clk_sys  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; one clock, synchronous, active-low.
REQ-005 SHALL have port ps2_clk  input  1  asynchronous PS/2 clock line.
REQ-006 SHALL have port ps2_data  input  1  asynchronous PS/2 data line.
REQ-007 SHALL have port key_strobe  output  1  one-cycle pulse marking a new key event.
REQ-008 SHALL have port key_pressed  output  1  1 = make, 0 = break.
REQ-009 SHALL have port key_extended  output  1  event was E0-prefixed.
REQ-010 SHALL have port key_code  output  8  scan code of the event.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on a dropped frame.

Function
REQ-012 SHALL pass ps2_clk and ps2_data through a 2-flop synchronizer each.
REQ-013 SHALL change the filtered clock only after FILTER_LEN consecutive identical synchronized samples.
REQ-014 SHALL sample synchronized ps2_data in the cycle a filtered-clock falling edge is detected.
REQ-015 SHALL run FSM IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE, advancing one state or bit per falling edge.
REQ-016 SHALL stay in IDLE, with no error, if the sampled start bit is 1.
REQ-017 SHALL drop the frame, pulse frame_err and return to IDLE if the stop bit is 0.
REQ-018 SHALL drop the frame, pulse frame_err and return to IDLE if TIMEOUT_CYC cycles pass without a falling edge while not in IDLE; the counter is cleared on every edge.
REQ-019 SHALL set the extended flag and emit no strobe on an accepted byte 0xE0.
REQ-020 SHALL set the break flag and emit no strobe on an accepted byte 0xF0.
REQ-021 SHALL discard an accepted byte 0xE1 and the following 7 accepted bytes, with no strobe and flags unchanged.
REQ-022 SHALL, on any other accepted byte, pulse key_strobe for exactly one cycle, one cycle after the stop-bit edge.
REQ-023 SHALL, with that strobe, present key_code = byte, key_pressed = NOT break flag and key_extended = extended flag, then clear both flags.
REQ-024 SHALL hold key_code, key_pressed and key_extended stable until the next key_strobe.
REQ-025 SHALL clear the extended flag, break flag and E1 discard count on every frame_err.
REQ-026 SHALL allow prefixes in any order (E0 F0 xx or F0 E0 xx), each yielding the same event.

Reset
REQ-027 SHALL, while reset_n = 0, set key_strobe, key_pressed, key_extended, frame_err to 0 and key_code to 0x00.
REQ-028 SHALL, while reset_n = 0, set FSM to IDLE, clear flags, bit and timeout counters, and set filter state to 1.
REQ-029 SHALL abandon any partial frame on reset, with no strobe or error afterwards.

Configuration
REQ-030 SHALL, when PS2_PARITY_CHECK_EN is defined, drop a frame with even parity over data+parity and pulse frame_err.
REQ-031 SHALL, when PS2_PARITY_CHECK_EN is undefined, ignore the parity bit, which is still consumed as a frame bit.

Structure
REQ-032 SHALL take from shared package ps2_pkg the FSM state enum and the constants PS2_EXT = 8'hE0, PS2_BRK = 8'hF0 and PS2_PAUSE = 8'hE1.
REQ-033 SHALL implement the synchronizer and glitch filter as sub-module ps2_filter, one instance per line.

Verification
REQ-034 SHALL cover: frame 0x1C, parity OK -> one strobe, code 0x1C, pressed 1, extended 0.
REQ-035 SHALL cover: frames F0, 1C -> one strobe only, code 0x1C, pressed 0, extended 0.
REQ-036 SHALL cover: frames E0, F0, 75 -> one strobe, code 0x75, pressed 0, extended 1.
REQ-037 SHALL cover: frame 0x45 with bad parity -> with PS2_PARITY_CHECK_EN no strobe and one frame_err; without it, a strobe with code 0x45.
REQ-038 SHALL cover: ps2_clk stopped after 4 data bits for TIMEOUT_CYC+1 cycles -> one frame_err, then frame 0x16 -> strobe, code 0x16.
REQ-039 SHALL cover: 2-cycle ps2_clk glitches with FILTER_LEN = 8 -> no bit sampled; E1 plus 7 bytes, then 0x29 -> exactly one strobe, code 0x29.
